// File: rtl/meas_discriminator.sv
// Per-core readout integrator: sums signed samples over a programmable window and
// emits a thresholded state bit with a one-cycle valid strobe per decision.
module meas_discriminator #(
    parameter int N_CORES      = 5,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int WIN_WIDTH    = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [SAMPLE_WIDTH-1:0] sample       [N_CORES-1:0],
    input  logic        [N_CORES-1:0]      sample_valid,
    input  logic        [N_CORES-1:0]      meas_start,
    input  logic        [WIN_WIDTH-1:0]    win_len,
    input  logic signed [ACC_WIDTH-1:0]    threshold    [N_CORES-1:0],
    output logic        [N_CORES-1:0]      meas,
    output logic        [N_CORES-1:0]      meas_valid,
    output logic        [N_CORES-1:0]      busy,
    output logic        [2*N_CORES-1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACC    = 2'd1;
    localparam logic [1:0] S_DECIDE = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [WIN_WIDTH-1:0]        CNT_ONE = {{(WIN_WIDTH-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
        logic [1:0]                  state_q, state_d;
        logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
        logic signed [ACC_WIDTH-1:0] thr_q, thr_d;
        logic [WIN_WIDTH-1:0]        cnt_q, cnt_d;
        logic [WIN_WIDTH-1:0]        len_q, len_d;
        logic [WIN_WIDTH-1:0]        cnt_inc;
        logic                        meas_q, meas_d;
        logic                        mv_q, mv_d;
        logic signed [ACC_WIDTH:0]   sum;
        logic signed [ACC_WIDTH-1:0] sat_sum;

        // One guard bit: overflow shows up as the two top bits disagreeing.
        always_comb begin
            sum = {acc_q[ACC_WIDTH-1], acc_q}
                + {{(ACC_WIDTH+1-SAMPLE_WIDTH){sample[i][SAMPLE_WIDTH-1]}}, sample[i]};
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                sat_sum = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
                sat_sum = sum[ACC_WIDTH-1:0];
            end
        end

        assign cnt_inc = cnt_q + CNT_ONE;

        always_comb begin
            state_d = state_q;
            acc_d   = acc_q;
            cnt_d   = cnt_q;
            len_d   = len_q;
            thr_d   = thr_q;
            meas_d  = meas_q;
            mv_d    = 1'b0;
            case (state_q)
                S_ACC: begin
                    if (sample_valid[i]) begin
                        acc_d = sat_sum;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = S_DECIDE;
                        end
                    end
                end
                S_DECIDE: begin
                    meas_d  = (acc_q >= thr_q);
                    mv_d    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            // A start overrides any sample this cycle but never cancels a decision.
            if (meas_start[i]) begin
                acc_d   = '0;
                cnt_d   = '0;
                len_d   = win_len;
                thr_d   = threshold[i];
                state_d = (win_len == '0) ? S_DECIDE : S_ACC;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
                acc_q   <= '0;
                thr_q   <= '0;
                cnt_q   <= '0;
                len_q   <= '0;
                meas_q  <= 1'b0;
                mv_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                acc_q   <= acc_d;
                thr_q   <= thr_d;
                cnt_q   <= cnt_d;
                len_q   <= len_d;
                meas_q  <= meas_d;
                mv_q    <= mv_d;
            end
        end

        assign meas[i]           = meas_q;
        assign meas_valid[i]     = mv_q;
        assign busy[i]           = (state_q != S_IDLE);
        assign dbg_state[2*i +: 2] = state_q;
    end

endmodule
